// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong frame buffer emitting FFT frames in bit-reversed or arrival order
module fft_bitrev_reorder #(
    parameter int N_PTS = 32,
    parameter int DW    = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_i,
    input  logic          bitrev_en,
    input  logic          ready_i,
    output logic          in_ready_o,
    output logic          valid_o,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_i,
    output logic          last_o,
    output logic          ovf_o
);

    localparam int AW = $clog2(N_PTS);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_PTS - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t   bank_state [2];
    logic [1:0]    bank_mode;
    logic [2*DW-1:0] mem [2*N_PTS];

    logic          wr_bank;
    logic [AW-1:0] wr_cnt;
    logic          rd_ptr;
    logic          rd_busy;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_addr;
    logic          out_bank;

    logic          accept;
    logic          out_free;
    logic          release_now;
    logic          start_rd;
    logic          fetch;

    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = a[AW-1-b];
        end
        return r;
    endfunction

    // A draining bank whose final sample is consumed this cycle counts as free,
    // so back-to-back frames neither stall the writer nor leave a read bubble.
    always_comb begin
        release_now = valid_o && last_o && ready_i;
        out_free    = !valid_o || ready_i;
        in_ready_o  = !rst && (bank_state[wr_bank] == EMPTY ||
                               bank_state[wr_bank] == FILLING ||
                               (bank_state[wr_bank] == DRAINING && release_now));
        accept      = valid_i && in_ready_o;
        start_rd    = !rd_busy && bank_state[rd_ptr] == FULL && out_free &&
                      (bank_state[~rd_ptr] != DRAINING || release_now);
        fetch       = (rd_busy && out_free) || start_rd;
        rd_addr     = bank_mode[rd_ptr] ? bit_reverse(rd_cnt) : rd_cnt;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{wr_bank, wr_cnt}] <= {in_r, in_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            bank_mode     <= '0;
            wr_bank       <= 1'b0;
            wr_cnt        <= '0;
            rd_ptr        <= 1'b0;
            rd_busy       <= 1'b0;
            rd_cnt        <= '0;
            out_bank      <= 1'b0;
            valid_o       <= 1'b0;
            last_o        <= 1'b0;
            out_r         <= '0;
            out_i         <= '0;
            ovf_o         <= 1'b0;
        end else begin
            if (release_now) begin
                bank_state[out_bank] <= EMPTY;
            end
            if (start_rd) begin
                bank_state[rd_ptr] <= DRAINING;
                out_bank           <= rd_ptr;
            end

            if (fetch) begin
                {out_r, out_i} <= mem[{rd_ptr, rd_addr}];
                valid_o        <= 1'b1;
                last_o         <= (rd_cnt == LAST_IDX);
                if (rd_cnt == LAST_IDX) begin
                    rd_cnt  <= '0;
                    rd_busy <= 1'b0;
                    rd_ptr  <= ~rd_ptr;
                end else begin
                    rd_cnt  <= rd_cnt + AW'(1);
                    rd_busy <= 1'b1;
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end

            // Write updates come last so a bank released and refilled in one cycle ends FILLING.
            if (accept) begin
                if (wr_cnt == '0) begin
                    bank_mode[wr_bank]  <= bitrev_en;
                    bank_state[wr_bank] <= FILLING;
                end
                if (wr_cnt == LAST_IDX) begin
                    bank_state[wr_bank] <= FULL;
                    wr_cnt              <= '0;
                    wr_bank             <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + AW'(1);
                end
            end

            ovf_o <= valid_i && !in_ready_o;
        end
    end

endmodule
